pipeline_sequencer: RTL and testbench

//  Owns the fetch PC and sequences the 5-stage 16-bit core (IF/ID/EX/MEM/WB, no forwarding).

---
 rtl/pipe_seq_pkg.sv | 14 +
 rtl/pipe_hazard_cmp.sv | 35 +++
 rtl/pipeline_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seq_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings and the
// number of drain cycles needed to empty EX, MEM and WB after ID goes empty.
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  localparam logic [2:0] DRAIN_TAIL = 3'd3;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// RAW hazard comparator: flags when the instruction in ID reads a register
// that an older instruction in EX or MEM has not yet written back. WB is not
// checked because the register file writes before it reads.
module pipe_hazard_cmp #(
  parameter int RA_W = 3
) (
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  output logic            hazard
);

  // A producer only matters if it writes a non-zero register; rs2 is only
  // compared when the ID instruction actually reads it.
  function automatic logic rd_hits(input logic            wr,
                                   input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] rs1,
                                   input logic [RA_W-1:0] rs2,
                                   input logic            use_rs2);
    return wr && (rd != '0) && ((rd == rs1) || (use_rs2 && (rd == rs2)));
  endfunction

  // Combine EX and MEM producer checks, qualified by a live ID instruction.
  always_comb begin
    hazard = id_valid &&
             (rd_hits(ex_reg_write, ex_rd, id_rs1, id_rs2, id_use_rs2) ||
              rd_hits(mem_reg_write, mem_rd, id_rs1, id_rs2, id_use_rs2));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Fetch PC owner and run/halt/single-step sequencer for the 5-stage 16-bit
// core. Stalls IF/ID and bubbles ID/EX on RAW hazards, flushes IF/ID on an
// ID-resolved redirect, and drains the pipe before returning to IDLE.
// Optional build macro PIPE_SEQ_PERF_EN adds saturating cycle, issue and
// stall counters.
module pipeline_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int RA_W   = 3,
  parameter int STEP_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              halt_i,
  input  logic              step_i,
  input  logic [STEP_W-1:0] step_cnt_i,
  input  logic [RA_W-1:0]   id_rs1_i,
  input  logic [RA_W-1:0]   id_rs2_i,
  input  logic              id_use_rs2_i,
  input  logic [RA_W-1:0]   ex_rd_i,
  input  logic              ex_reg_write_i,
  input  logic [RA_W-1:0]   mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   pc_target_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              ifid_stall_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic [1:0]        state_o,
  output logic              done_o
`ifdef PIPE_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]  cyc_cnt_o,
  output logic [CNT_W-1:0]  instr_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  seq_state_t        state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_n;
  logic              id_valid_q;
  logic [STEP_W-1:0] remaining_q;
  logic [2:0]        drain_cnt_q;
  logic              done_q;
  logic              hazard;
  logic              issue;
  logic              last_issue;

  pipe_hazard_cmp #(
    .RA_W (RA_W)
  ) u_hazard (
    .id_valid      (id_valid_q),
    .id_rs1        (id_rs1_i),
    .id_rs2        (id_rs2_i),
    .id_use_rs2    (id_use_rs2_i),
    .ex_rd         (ex_rd_i),
    .ex_reg_write  (ex_reg_write_i),
    .mem_rd        (mem_rd_i),
    .mem_reg_write (mem_reg_write_i),
    .hazard        (hazard)
  );

  assign issue      = id_valid_q && !hazard;
  assign last_issue = (state_q == ST_STEP) && issue && (remaining_q == STEP_W'(1));
  assign pc_o       = pc_q;
  assign state_o    = state_q;
  assign done_o     = done_q;

  // Pipeline control outputs and next PC from current state and ID/EX/MEM view.
  always_comb begin
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b1;
    idex_bubble_o = 1'b1;
    pc_n          = pc_q;
    if (rst_i) begin
      unique case (state_q)
        ST_RUN, ST_STEP: begin
          idex_bubble_o = !issue;
          if (hazard) begin
            ifid_stall_o = 1'b1;
            ifid_flush_o = 1'b0;
          end else if (redirect_i) begin
            pc_n         = pc_target_i;
            ifid_flush_o = 1'b1;
          end else begin
            pc_n         = pc_q + PC_W'(1);
            ifid_flush_o = last_issue;
          end
        end
        ST_DRAIN: begin
          idex_bubble_o = !issue;
          if (hazard) begin
            ifid_stall_o = 1'b1;
            ifid_flush_o = 1'b0;
          end else if (redirect_i) begin
            pc_n = pc_target_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM with PC, ID occupancy, step budget and drain tail counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      id_valid_q  <= 1'b0;
      remaining_q <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      pc_q       <= pc_n;
      id_valid_q <= ifid_flush_o ? 1'b0 : (ifid_stall_o ? id_valid_q : 1'b1);
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (halt_i) begin
            state_q <= ST_IDLE;
          end else if (run_i) begin
            state_q <= ST_RUN;
          end else if (step_i) begin
            state_q     <= ST_STEP;
            remaining_q <= (step_cnt_i == '0) ? STEP_W'(1) : step_cnt_i;
          end
        end
        ST_RUN: begin
          if (halt_i) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= DRAIN_TAIL;
          end
        end
        ST_STEP: begin
          if (issue) remaining_q <= remaining_q - STEP_W'(1);
          if (halt_i || last_issue) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= DRAIN_TAIL;
          end
        end
        ST_DRAIN: begin
          // The tail only starts counting once ID holds nothing left to issue.
          if (id_valid_q) begin
            drain_cnt_q <= DRAIN_TAIL;
          end else if (drain_cnt_q == 3'd1) begin
            drain_cnt_q <= '0;
            done_q      <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q - 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_SEQ_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating activity counters: busy cycles, issued instructions, hazard stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cyc_cnt_o   <= '0;
      instr_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (state_q != ST_IDLE) cyc_cnt_o   <= sat_inc(cyc_cnt_o);
      if (issue)              instr_cnt_o <= sat_inc(instr_cnt_o);
      if (hazard)             stall_cnt_o <= sat_inc(stall_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer.
module tb_pipeline_sequencer;

  localparam int PC_W   = 8;
  localparam int RA_W   = 3;
  localparam int STEP_W = 8;
  localparam int CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              run_i = 1'b0;
  logic              halt_i = 1'b0;
  logic              step_i = 1'b0;
  logic [STEP_W-1:0] step_cnt_i = '0;
  logic [RA_W-1:0]   id_rs1_i = '0;
  logic [RA_W-1:0]   id_rs2_i = '0;
  logic              id_use_rs2_i = 1'b0;
  logic [RA_W-1:0]   ex_rd_i = '0;
  logic              ex_reg_write_i = 1'b0;
  logic [RA_W-1:0]   mem_rd_i = '0;
  logic              mem_reg_write_i = 1'b0;
  logic              redirect_i = 1'b0;
  logic [PC_W-1:0]   pc_target_i = '0;
  logic [PC_W-1:0]   pc_o;
  logic              ifid_stall_o;
  logic              ifid_flush_o;
  logic              idex_bubble_o;
  logic [1:0]        state_o;
  logic              done_o;
`ifdef PIPE_SEQ_PERF_EN
  logic [CNT_W-1:0]  cyc_cnt_o;
  logic [CNT_W-1:0]  instr_cnt_o;
  logic [CNT_W-1:0]  stall_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pipeline_sequencer #(
    .PC_W   (PC_W),
    .RA_W   (RA_W),
    .STEP_W (STEP_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .run_i           (run_i),
    .halt_i          (halt_i),
    .step_i          (step_i),
    .step_cnt_i      (step_cnt_i),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_use_rs2_i    (id_use_rs2_i),
    .ex_rd_i         (ex_rd_i),
    .ex_reg_write_i  (ex_reg_write_i),
    .mem_rd_i        (mem_rd_i),
    .mem_reg_write_i (mem_reg_write_i),
    .redirect_i      (redirect_i),
    .pc_target_i     (pc_target_i),
    .pc_o            (pc_o),
    .ifid_stall_o    (ifid_stall_o),
    .ifid_flush_o    (ifid_flush_o),
    .idex_bubble_o   (idex_bubble_o),
    .state_o         (state_o),
    .done_o          (done_o)
`ifdef PIPE_SEQ_PERF_EN
    ,
    .cyc_cnt_o       (cyc_cnt_o),
    .instr_cnt_o     (instr_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Issue a step request and watch it to completion within a bounded window.
  task automatic run_step(input logic [STEP_W-1:0] cnt, output int issues, output int lag,
                          output logic [1:0] st_first, output logic [1:0] st_after,
                          output logic [1:0] st_done);
    int last;
    int done_at;
    step_i     = 1'b1;
    step_cnt_i = cnt;
    settle();
    tick();
    step_i   = 1'b0;
    issues   = 0;
    last     = -1;
    done_at  = -1;
    st_first = 2'd0;
    st_after = 2'd0;
    st_done  = 2'd1;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (c == 0) st_first = state_o;
      if (!idex_bubble_o) begin
        issues++;
        last = c;
      end else if (last >= 0 && c == last + 1) begin
        st_after = state_o;
      end
      if (done_o) begin
        done_at = c;
        st_done = state_o;
        break;
      end
      tick();
    end
    lag = (done_at < 0) ? -1 : done_at - last;
  endtask

  initial begin
    int         issues;
    int         lag;
    logic [1:0] s_first;
    logic [1:0] s_after;
    logic [1:0] s_done;
    logic       any_done;

    // Reset
    tick();
    check("rst_pc", 32'(pc_o), 32'h0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_flush", 32'(ifid_flush_o), 32'd1);
    check("rst_bubble", 32'(idex_bubble_o), 32'd1);
    check("rst_stall", 32'(ifid_stall_o), 32'd0);

    // Start running, straight-line fetch
    rst_i = 1'b1;
    run_i = 1'b1;
    settle();
    check("idle_flush", 32'(ifid_flush_o), 32'd1);
    tick();
    run_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("run_pc", 32'(pc_o), 32'(i));
      check("run_bubble", 32'(idex_bubble_o), (i == 0) ? 32'd1 : 32'd0);
      tick();
    end
    check("run_pc5", 32'(pc_o), 32'h5);
    check("run_state", 32'(state_o), 32'd1);

    // EX hazard on rs1
    ex_rd_i = 3'd3; ex_reg_write_i = 1'b1; id_rs1_i = 3'd3;
    settle();
    check("ex_haz_stall", 32'(ifid_stall_o), 32'd1);
    check("ex_haz_bubble", 32'(idex_bubble_o), 32'd1);
    check("ex_haz_flush", 32'(ifid_flush_o), 32'd0);
    tick();
    check("ex_haz_pc", 32'(pc_o), 32'h5);

    // MEM hazard on rs1
    ex_rd_i = 3'd0; ex_reg_write_i = 1'b0; mem_rd_i = 3'd3; mem_reg_write_i = 1'b1;
    settle();
    check("mem_haz_stall", 32'(ifid_stall_o), 32'd1);
    tick();
    check("mem_haz_pc", 32'(pc_o), 32'h5);

    // rs2 match but rs2 unused: no stall; then with rs2 used: stall
    mem_rd_i = 3'd0; mem_reg_write_i = 1'b0; id_rs1_i = 3'd0;
    id_rs2_i = 3'd2; ex_rd_i = 3'd2; ex_reg_write_i = 1'b1; id_use_rs2_i = 1'b0;
    settle();
    check("rs2_unused_stall", 32'(ifid_stall_o), 32'd0);
    check("rs2_unused_bubble", 32'(idex_bubble_o), 32'd0);
    id_use_rs2_i = 1'b1;
    settle();
    check("rs2_used_stall", 32'(ifid_stall_o), 32'd1);
    id_use_rs2_i = 1'b0;
    settle();
    tick();
    check("rs2_unused_pc", 32'(pc_o), 32'h6);

    // Writes to r0 never stall
    ex_rd_i = 3'd0; ex_reg_write_i = 1'b1; id_rs1_i = 3'd0; id_rs2_i = 3'd0;
    id_use_rs2_i = 1'b1; mem_rd_i = 3'd0; mem_reg_write_i = 1'b1;
    settle();
    check("r0_stall", 32'(ifid_stall_o), 32'd0);
    tick();
    check("r0_pc", 32'(pc_o), 32'h7);
    ex_reg_write_i = 1'b0; mem_reg_write_i = 1'b0; id_use_rs2_i = 1'b0;

    // Redirect with a hazard is ignored
    redirect_i = 1'b1; pc_target_i = 8'h40;
    ex_rd_i = 3'd3; ex_reg_write_i = 1'b1; id_rs1_i = 3'd3;
    settle();
    check("redir_haz_flush", 32'(ifid_flush_o), 32'd0);
    tick();
    check("redir_haz_pc", 32'(pc_o), 32'h7);

    // Redirect taken
    ex_rd_i = 3'd0; ex_reg_write_i = 1'b0; id_rs1_i = 3'd0;
    settle();
    check("redir_flush", 32'(ifid_flush_o), 32'd1);
    tick();
    redirect_i = 1'b0;
    check("redir_pc", 32'(pc_o), 32'h40);
    settle();
    check("redir_bubble", 32'(idex_bubble_o), 32'd1);
    tick();
    check("redir_pc_next", 32'(pc_o), 32'h41);

    // Halt beats run, then drain to IDLE
    halt_i = 1'b1; run_i = 1'b1;
    settle();
    tick();
    halt_i = 1'b0; run_i = 1'b0;
    settle();
    check("halt_state", 32'(state_o), 32'd3);
    check("drain_issue_flush", 32'(ifid_flush_o), 32'd1);
    check("drain_issue_bubble", 32'(idex_bubble_o), 32'd0);
    tick();
    check("drain_pc_held", 32'(pc_o), 32'h42);
    check("drain_done0", 32'(done_o), 32'd0);
    tick();
    check("drain_done1", 32'(done_o), 32'd0);
    tick();
    check("drain_done2", 32'(done_o), 32'd0);
    tick();
    check("drain_done", 32'(done_o), 32'd1);
    check("drain_idle", 32'(state_o), 32'd0);
    tick();
    check("drain_done_pulse", 32'(done_o), 32'd0);

    // Single step of 3
    run_step(8'd3, issues, lag, s_first, s_after, s_done);
    check("step3_state", 32'(s_first), 32'd2);
    check("step3_issues", 32'(issues), 32'd3);
    check("step3_drain", 32'(s_after), 32'd3);
    check("step3_lag", 32'(lag), 32'd4);
    check("step3_idle", 32'(s_done), 32'd0);

    // Step count 0 behaves as 1
    run_step(8'd0, issues, lag, s_first, s_after, s_done);
    check("step0_issues", 32'(issues), 32'd1);
    check("step0_lag", 32'(lag), 32'd4);

    // Reset during DRAIN aborts without done
    run_i = 1'b1;
    settle();
    tick();
    run_i = 1'b0;
    tick();
    tick();
    halt_i = 1'b1;
    settle();
    tick();
    halt_i = 1'b0;
    settle();
    check("abort_drain_state", 32'(state_o), 32'd3);
    rst_i = 1'b0;
    settle();
    check("abort_rst_bubble", 32'(idex_bubble_o), 32'd1);
    check("abort_rst_flush", 32'(ifid_flush_o), 32'd1);
    tick();
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_pc", 32'(pc_o), 32'h0);
    rst_i = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      any_done = any_done | done_o;
      tick();
    end
    check("abort_no_done", 32'(any_done), 32'd0);

    // PC wraps from all-ones to zero
    run_i = 1'b1;
    settle();
    tick();
    run_i = 1'b0;
    redirect_i = 1'b1; pc_target_i = 8'hFF;
    settle();
    tick();
    redirect_i = 1'b0;
    check("wrap_pc_ff", 32'(pc_o), 32'hFF);
    settle();
    tick();
    check("wrap_pc_0", 32'(pc_o), 32'h0);

`ifdef PIPE_SEQ_PERF_EN
    begin
      logic [CNT_W-1:0] i0;
      logic [CNT_W-1:0] s0;
      i0 = instr_cnt_o;
      s0 = stall_cnt_o;
      for (int c = 0; c < 10; c++) begin
        if (c == 2 || c == 5) begin
          ex_rd_i = 3'd3; ex_reg_write_i = 1'b1; id_rs1_i = 3'd3;
        end else begin
          ex_rd_i = 3'd0; ex_reg_write_i = 1'b0; id_rs1_i = 3'd0;
        end
        settle();
        tick();
      end
      ex_rd_i = 3'd0; ex_reg_write_i = 1'b0; id_rs1_i = 3'd0;
      check("perf_stalls", 32'(stall_cnt_o - s0), 32'd2);
      check("perf_instrs", 32'(instr_cnt_o - i0), 32'd8);
    end
`endif

    // Halt and wait for the pipe to drain
    halt_i = 1'b1;
    settle();
    tick();
    halt_i = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (done_o) begin
        any_done = 1'b1;
        break;
      end
      tick();
    end
    check("final_done", 32'(any_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
